// File: rtl/sdram_port_arbiter.sv
// ---------------------------------------------------------------------------
// sdram_port_arbiter
//
// N-port front end for sdram_controller. One port at a time owns the
// controller. Its address, write data, write enable and focus are routed
// through, and only that port sees the controller's ready. Ownership is
// handed over only when the controller reports ready, so an access is never
// switched mid-flight. After the owner drops req, a hold window keeps
// ownership with it for HOLD_CYCLES cycles. This lets a bursty owner come
// back without re-arbitrating.
//
// Ports:
//   Clk          system clock
//   Reset        asynchronous, active-low reset
//   req          per-port ownership request (level)
//   addr         packed per-port word address, port i at [i*ADDR_W +: ADDR_W]
//   din          packed per-port write data,  port i at [i*DATA_W +: DATA_W]
//   we           per-port write enable
//   focus        per-port refresh inhibit
//   grant        one-hot current owner (DEFAULT_PORT when nobody owns it)
//   r            per-port ready, sdram_R gated by grant
//   dout         controller read data, broadcast to every port
//   sdram_Addr   fields of the granted port, to the controller
//   sdram_Din    fields of the granted port, to the controller
//   sdram_WE     fields of the granted port, to the controller
//   sdram_Focus  fields of the granted port, to the controller
//   sdram_R      controller ready
//   sdram_Dout   controller read data
// ---------------------------------------------------------------------------
module sdram_port_arbiter #(
    parameter int                NUM_PORTS    = 2,
    parameter int                ADDR_W       = 25,
    parameter int                DATA_W       = 16,
    parameter int                HOLD_W       = 24,
    parameter logic [HOLD_W-1:0] HOLD_CYCLES  = 24'hFFFFFF,
    parameter int                RR_MODE      = 0,
    parameter int                DEFAULT_PORT = 0
) (
    input  logic                        Clk,
    input  logic                        Reset,
    input  logic [NUM_PORTS-1:0]        req,
    input  logic [NUM_PORTS*ADDR_W-1:0] addr,
    input  logic [NUM_PORTS*DATA_W-1:0] din,
    input  logic [NUM_PORTS-1:0]        we,
    input  logic [NUM_PORTS-1:0]        focus,
    output logic [NUM_PORTS-1:0]        grant,
    output logic [NUM_PORTS-1:0]        r,
    output logic [DATA_W-1:0]           dout,
    output logic [ADDR_W-1:0]           sdram_Addr,
    output logic [DATA_W-1:0]           sdram_Din,
    output logic                        sdram_WE,
    output logic                        sdram_Focus,
    input  logic                        sdram_R,
    input  logic [DATA_W-1:0]           sdram_Dout
);

    localparam int PTR_W = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
    localparam logic [NUM_PORTS-1:0] ONE_HOT0      = {{(NUM_PORTS-1){1'b0}}, 1'b1};
    localparam logic [NUM_PORTS-1:0] DEFAULT_GRANT = ONE_HOT0 << DEFAULT_PORT;
    localparam logic [PTR_W-1:0]     RR_RESET      = PTR_W'(NUM_PORTS - 1);
    // The window covers HOLD_CYCLES edges. The edge that enters HOLD already
    // counts, so the counter starts one below the window length.
    localparam logic [HOLD_W-1:0]    HOLD_LOAD     = HOLD_CYCLES - HOLD_W'(1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN  = 2'd1,
        HOLD = 2'd2
    } state_t;

    state_t               state, state_nxt;
    logic [NUM_PORTS-1:0] grant_nxt;
    logic [HOLD_W-1:0]    hold_cnt, hold_nxt;
    logic [PTR_W-1:0]     rr_ptr, rr_nxt;

    logic                 owner_req;
    logic [PTR_W-1:0]     win_idx;
    logic                 win_found;
    logic [NUM_PORTS-1:0] win_grant;
    logic                 do_expiry;

    // Datapath: AND-OR mux on the one-hot grant, so an invalid index never
    // reaches a part select.
    always_comb begin
        sdram_Addr  = '0;
        sdram_Din   = '0;
        sdram_WE    = 1'b0;
        sdram_Focus = 1'b0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            if (grant[i]) begin
                sdram_Addr  = addr[i*ADDR_W +: ADDR_W];
                sdram_Din   = din[i*DATA_W +: DATA_W];
                sdram_WE    = we[i];
                sdram_Focus = focus[i];
            end
        end
    end

    assign dout      = sdram_Dout;
    assign r         = grant & {NUM_PORTS{sdram_R}};
    assign owner_req = |(req & grant);

    // Arbitration: pick the winner among the requesting ports.
    always_comb begin
        win_idx   = '0;
        win_found = 1'b0;
        if (RR_MODE != 0) begin
            // Search upward starting just past the last winner.
            for (int k = 1; k <= NUM_PORTS; k++) begin
                if (!win_found && req[(int'(rr_ptr) + k) % NUM_PORTS]) begin
                    win_idx   = PTR_W'((int'(rr_ptr) + k) % NUM_PORTS);
                    win_found = 1'b1;
                end
            end
        end else begin
            // Fixed priority: the lowest set index wins.
            for (int i = NUM_PORTS - 1; i >= 0; i--) begin
                if (req[i]) begin
                    win_idx   = PTR_W'(i);
                    win_found = 1'b1;
                end
            end
        end
    end

    assign win_grant = ONE_HOT0 << win_idx;

    always_comb begin
        state_nxt = state;
        grant_nxt = grant;
        hold_nxt  = hold_cnt;
        rr_nxt    = rr_ptr;
        do_expiry = 1'b0;

        case (state)
            IDLE: begin
                if (win_found && sdram_R) begin
                    grant_nxt = win_grant;
                    rr_nxt    = win_idx;
                    state_nxt = OWN;
                end else begin
                    grant_nxt = DEFAULT_GRANT;
                end
            end
            OWN: begin
                if (!owner_req) begin
                    if (HOLD_CYCLES == '0) begin
                        do_expiry = 1'b1;
                    end else begin
                        hold_nxt  = HOLD_LOAD;
                        state_nxt = HOLD;
                    end
                end
            end
            HOLD: begin
                if (owner_req) begin
                    // Owner came back. The next release starts a fresh window.
                    hold_nxt  = '0;
                    state_nxt = OWN;
                end else if (hold_cnt != '0) begin
                    hold_nxt = hold_cnt - HOLD_W'(1);
                end else begin
                    do_expiry = 1'b1;
                end
            end
            default: begin
                grant_nxt = DEFAULT_GRANT;
                hold_nxt  = '0;
                state_nxt = IDLE;
            end
        endcase

        // Handover waits for the controller to be ready. Until then, hold
        // ownership with the counter parked at zero.
        if (do_expiry) begin
            if (sdram_R) begin
                if (win_found) begin
                    grant_nxt = win_grant;
                    rr_nxt    = win_idx;
                    state_nxt = OWN;
                end else begin
                    grant_nxt = DEFAULT_GRANT;
                    state_nxt = IDLE;
                end
            end else begin
                hold_nxt  = '0;
                state_nxt = HOLD;
            end
        end
    end

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state    <= IDLE;
            grant    <= DEFAULT_GRANT;
            hold_cnt <= '0;
            rr_ptr   <= RR_RESET;
        end else begin
            state    <= state_nxt;
            grant    <= grant_nxt;
            hold_cnt <= hold_nxt;
            rr_ptr   <= rr_nxt;
        end
    end

endmodule

// File: tb/tb_sdram_port_arbiter.sv
// ---------------------------------------------------------------------------
// tb_sdram_port_arbiter
//
// Directed bench for three configurations of sdram_port_arbiter:
//   A: 2 ports, fixed priority, 4-cycle hold, default port 0
//   B: 4 ports, round robin, no hold, default port 0
//   C: 2 ports, fixed priority, 120-cycle hold, default port 1
// ---------------------------------------------------------------------------
module tb_sdram_port_arbiter;

    logic Clk;
    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    int n_vec  = 0;
    int n_miss = 0;

    logic [15:0] sdout;

    // ---------------- instance A ----------------
    logic        rst_a;
    logic [1:0]  req_a, we_a, focus_a, grant_a, r_a;
    logic [49:0] addr_a;
    logic [31:0] din_a;
    logic [15:0] dout_a, sdin_a;
    logic [24:0] saddr_a;
    logic        swe_a, sfocus_a, srdy_a;

    sdram_port_arbiter #(
        .NUM_PORTS(2), .ADDR_W(25), .DATA_W(16), .HOLD_W(24),
        .HOLD_CYCLES(24'd4), .RR_MODE(0), .DEFAULT_PORT(0)
    ) dut_a (
        .Clk(Clk), .Reset(rst_a), .req(req_a), .addr(addr_a), .din(din_a),
        .we(we_a), .focus(focus_a), .grant(grant_a), .r(r_a), .dout(dout_a),
        .sdram_Addr(saddr_a), .sdram_Din(sdin_a), .sdram_WE(swe_a),
        .sdram_Focus(sfocus_a), .sdram_R(srdy_a), .sdram_Dout(sdout)
    );

    // ---------------- instance B ----------------
    logic         rst_b;
    logic [3:0]   req_b, we_b, focus_b, grant_b, r_b;
    logic [99:0]  addr_b;
    logic [63:0]  din_b;
    logic [15:0]  dout_b, sdin_b;
    logic [24:0]  saddr_b;
    logic         swe_b, sfocus_b, srdy_b;

    sdram_port_arbiter #(
        .NUM_PORTS(4), .ADDR_W(25), .DATA_W(16), .HOLD_W(24),
        .HOLD_CYCLES(24'd0), .RR_MODE(1), .DEFAULT_PORT(0)
    ) dut_b (
        .Clk(Clk), .Reset(rst_b), .req(req_b), .addr(addr_b), .din(din_b),
        .we(we_b), .focus(focus_b), .grant(grant_b), .r(r_b), .dout(dout_b),
        .sdram_Addr(saddr_b), .sdram_Din(sdin_b), .sdram_WE(swe_b),
        .sdram_Focus(sfocus_b), .sdram_R(srdy_b), .sdram_Dout(sdout)
    );

    // ---------------- instance C ----------------
    logic        rst_c;
    logic [1:0]  req_c, we_c, focus_c, grant_c, r_c;
    logic [49:0] addr_c;
    logic [31:0] din_c;
    logic [15:0] dout_c, sdin_c;
    logic [24:0] saddr_c;
    logic        swe_c, sfocus_c, srdy_c;

    sdram_port_arbiter #(
        .NUM_PORTS(2), .ADDR_W(25), .DATA_W(16), .HOLD_W(24),
        .HOLD_CYCLES(24'd120), .RR_MODE(0), .DEFAULT_PORT(1)
    ) dut_c (
        .Clk(Clk), .Reset(rst_c), .req(req_c), .addr(addr_c), .din(din_c),
        .we(we_c), .focus(focus_c), .grant(grant_c), .r(r_c), .dout(dout_c),
        .sdram_Addr(saddr_c), .sdram_Din(sdin_c), .sdram_WE(swe_c),
        .sdram_Focus(sfocus_c), .sdram_R(srdy_c), .sdram_Dout(sdout)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    logic [3:0] rr_seq [0:4];

    initial begin
        rr_seq[0] = 4'b0001; rr_seq[1] = 4'b0010; rr_seq[2] = 4'b0100;
        rr_seq[3] = 4'b1000; rr_seq[4] = 4'b0001;

        sdout   = 16'hBEEF;
        rst_a   = 1'b0; rst_b = 1'b0; rst_c = 1'b0;
        req_a   = 2'b00; we_a = 2'b10; focus_a = 2'b10; srdy_a = 1'b1;
        addr_a  = {25'h0000456, 25'h0000123};
        din_a   = {16'hD1D1, 16'hD0D0};
        req_b   = 4'b0000; we_b = 4'b0000; focus_b = 4'b0000; srdy_b = 1'b1;
        addr_b  = {25'h0000333, 25'h0000222, 25'h0000111, 25'h0000100};
        din_b   = 64'h0;
        req_c   = 2'b00; we_c = 2'b10; focus_c = 2'b00; srdy_c = 1'b1;
        addr_c  = {25'h0000AAA, 25'h0000555};
        din_c   = {16'h1111, 16'h0000};

        #12;
        rst_a = 1'b1; rst_b = 1'b1; rst_c = 1'b1;
        #1;

        // ---- reset state ----
        check("a_rst_grant", 64'(grant_a), 64'(2'b01));
        check("a_rst_addr",  64'(saddr_a), 64'(25'h0000123));
        check("a_rst_r",     64'(r_a),     64'(2'b01));
        check("a_rst_we",    64'(swe_a),   64'(1'b0));
        check("a_dout",      64'(dout_a),  64'(16'hBEEF));
        check("b_rst_grant", 64'(grant_b), 64'(4'b0001));
        check("c_rst_grant", 64'(grant_c), 64'(2'b10));
        check("c_rst_addr",  64'(saddr_c), 64'(25'h0000AAA));
        check("c_rst_r",     64'(r_c),     64'(2'b10));

        // ---- A: 3-cycle request from port 1, then 4-cycle hold ----
        req_a = 2'b10;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("a_own_grant", 64'(grant_a), 64'(2'b10));
        end
        check("a_own_addr",  64'(saddr_a),  64'(25'h0000456));
        check("a_own_din",   64'(sdin_a),   64'(16'hD1D1));
        check("a_own_we",    64'(swe_a),    64'(1'b1));
        check("a_own_focus", 64'(sfocus_a), 64'(1'b1));
        check("a_own_r",     64'(r_a),      64'(2'b10));
        req_a = 2'b00;
        for (int i = 0; i < 4; i++) begin
            tick();
            check("a_hold_grant", 64'(grant_a), 64'(2'b10));
        end
        tick();
        check("a_release_grant", 64'(grant_a), 64'(2'b01));
        check("a_release_addr",  64'(saddr_a), 64'(25'h0000123));

        // ---- A: re-assert during hold restarts the window ----
        req_a = 2'b10; tick();
        check("a_re_own", 64'(grant_a), 64'(2'b10));
        req_a = 2'b00; tick(); tick();
        req_a = 2'b10; tick();
        check("a_re_back", 64'(grant_a), 64'(2'b10));
        req_a = 2'b00;
        for (int i = 0; i < 4; i++) begin
            tick();
            check("a_re_hold", 64'(grant_a), 64'(2'b10));
        end
        tick();
        check("a_re_expire", 64'(grant_a), 64'(2'b01));

        // ---- A: controller not ready blocks handover ----
        srdy_a = 1'b0; req_a = 2'b10;
        for (int i = 0; i < 10; i++) begin
            tick();
            check("a_nr_idle", 64'(grant_a), 64'(2'b01));
        end
        check("a_nr_r", 64'(r_a), 64'(2'b00));
        srdy_a = 1'b1; tick();
        check("a_nr_grant", 64'(grant_a), 64'(2'b10));
        req_a = 2'b00; srdy_a = 1'b0;
        for (int i = 0; i < 7; i++) begin
            tick();
            check("a_nr_hold", 64'(grant_a), 64'(2'b10));
        end
        srdy_a = 1'b1; tick();
        check("a_nr_expire", 64'(grant_a), 64'(2'b01));

        // ---- A: simultaneous requests, default port protected by hold ----
        req_a = 2'b11; tick();
        check("a_pri_grant", 64'(grant_a), 64'(2'b01));
        req_a = 2'b10;
        for (int i = 0; i < 4; i++) begin
            tick();
            check("a_pri_hold", 64'(grant_a), 64'(2'b01));
        end
        tick();
        check("a_pri_handover", 64'(grant_a), 64'(2'b10));
        check("a_pri_addr",     64'(saddr_a), 64'(25'h0000456));

        // ---- B: round robin with all ports requesting, no hold ----
        req_b = 4'b1111; tick();
        check("b_rr_first", 64'(grant_b), 64'(rr_seq[0]));
        for (int i = 0; i < 4; i++) begin
            tick();
            check("b_rr_keep", 64'(grant_b), 64'(rr_seq[i]));
            req_b = 4'b1111 & ~rr_seq[i];
            tick();
            check("b_rr_next", 64'(grant_b), 64'(rr_seq[i+1]));
            req_b = 4'b1111;
        end
        check("b_rr_addr", 64'(saddr_b), 64'(25'h0000100));

        // ---- C: asynchronous reset in the middle of a long hold ----
        req_c = 2'b01; tick();
        check("c_own_grant", 64'(grant_c), 64'(2'b01));
        check("c_own_we",    64'(swe_c),   64'(1'b0));
        req_c = 2'b00;
        for (int i = 0; i < 20; i++) tick();
        check("c_hold_grant", 64'(grant_c), 64'(2'b01));
        #2;
        rst_c = 1'b0;
        #1;
        check("c_arst_grant", 64'(grant_c), 64'(2'b10));
        check("c_arst_we",    64'(swe_c),   64'(1'b1));
        check("c_arst_addr",  64'(saddr_c), 64'(25'h0000AAA));
        check("c_arst_r",     64'(r_c),     64'(2'b10));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

// File: doc/sdram_port_arbiter.md
Name: sdram_port_arbiter

Overview:
- Parametrised N-port front end for sdram_controller.
- Generalises the fixed two-way user/JTAG-DMA mux into NUM_PORTS requesters, with selectable fixed-priority or round-robin arbitration.
- A programmable post-release hold window keeps ownership with the last owner.
- Ownership changes only when the controller reports ready, so an access is never switched mid-flight.

Parameters:
- NUM_PORTS, 2, number of requesting ports (2..8).
- ADDR_W, 25, SDRAM word address width.
- DATA_W, 16, data width.
- HOLD_W, 24, width of the hold counter.
- HOLD_CYCLES, 24'hFFFFFF, cycles ownership is retained after the owner drops req; 0 means no hold.
- RR_MODE, 0: 0 = fixed priority (lowest index wins), 1 = round robin.
- DEFAULT_PORT, 0, port routed to the controller when no port owns it.

Ports:
- Clk, in, 1, system clock.
- Reset, in, 1, asynchronous, active-low reset.
- req, in, NUM_PORTS, per-port ownership request (level).
- addr, in, NUM_PORTS*ADDR_W, packed per-port address; port i at [i*ADDR_W +: ADDR_W].
- din, in, NUM_PORTS*DATA_W, packed per-port write data.
- we, in, NUM_PORTS, per-port write enable.
- focus, in, NUM_PORTS, per-port refresh-inhibit.
- grant, out, NUM_PORTS, one-hot current owner.
- r, out, NUM_PORTS, per-port ready: sdram_R gated by grant[i].
- dout, out, DATA_W, read data broadcast to all ports.
- sdram_Addr, out, ADDR_W, to controller.
- sdram_Din, out, DATA_W, to controller.
- sdram_WE, out, 1, to controller.
- sdram_Focus, out, 1, to controller.
- sdram_R, in, 1, controller ready.
- sdram_Dout, in, DATA_W, controller read data.

Behaviour:
- Datapath: sdram_Addr/Din/WE/Focus = fields of port sel. sel is the one-hot index held in grant, combinational from registered grant. dout = sdram_Dout. r[i] = sdram_R & grant[i].
- States: IDLE, OWN, HOLD. Registers: state, grant, hold_cnt (HOLD_W), rr_ptr.
- Reset (Reset=0, async):
  - state=IDLE, grant=one-hot(DEFAULT_PORT), hold_cnt=0, rr_ptr=NUM_PORTS-1.
  - All outputs follow DEFAULT_PORT; r[DEFAULT_PORT]=sdram_R, other r=0.
- Arbitration function win(req):
  - RR_MODE=0: lowest set index.
  - RR_MODE=1: first set index searching upward from rr_ptr+1 modulo NUM_PORTS.
- IDLE:
  - If |req && sdram_R: grant<=one-hot(win), state<=OWN, rr_ptr<=win.
  - Else stay IDLE with the default grant.
  - Latency: req high at edge k with sdram_R=1 gives the new grant and mux at k+1.
- OWN:
  - While req[owner]=1, stay; no preemption, other requests wait.
  - On req[owner]=0: if HOLD_CYCLES=0, act as HOLD expiry this edge. Else hold_cnt<=HOLD_CYCLES-1, state<=HOLD.
- HOLD: mux stays on owner.
  - req[owner] re-asserted: state<=OWN, hold_cnt<=0 (restart window on next release).
  - Else if hold_cnt!=0: hold_cnt<=hold_cnt-1.
  - Else (expiry), only when sdram_R=1:
    - if req has other bits set, grant<=one-hot(win), state<=OWN, rr_ptr<=win;
    - else grant<=one-hot(DEFAULT_PORT), state<=IDLE.
  - If sdram_R=0 at expiry, remain in HOLD with hold_cnt=0 until sdram_R=1.
- Simultaneous requests: resolved only by win(); exactly one grant bit is ever set.
- A DEFAULT_PORT request in IDLE still goes through OWN, so it gains hold protection.
- Reset asserted mid-operation returns to the reset state immediately, irrespective of the controller's state.
- focus is never overridden; the owner is responsible for limiting its duration.

Test Plan:
- Reset=0 then 1, no req: grant=1<<DEFAULT_PORT; port 0 addr 25'h0000123 appears on sdram_Addr same cycle; r[1]=0.
- NUM_PORTS=2, RR_MODE=0, HOLD_CYCLES=4, sdram_R=1: req[1] pulse 3 cycles → grant=2'b10 one cycle later. Grant held 3 req cycles + 4 hold cycles, then returns to 2'b01.
- RR_MODE=1, NUM_PORTS=4, req=4'b1111 held, each owner drops req after 2 cycles, HOLD_CYCLES=0 → grant sequence 0001,0010,0100,1000,0001.
- Owner drops req, re-asserts at hold_cnt=2 → state OWN, grant unchanged; after final drop a full HOLD_CYCLES window runs again.
- IDLE with req[1]=1 and sdram_R=0 for 10 cycles → grant stays default; grant=2'b10 one cycle after sdram_R rises.
- Reset asserted asynchronously while in HOLD with hold_cnt=100 → grant default and sdram_WE=we[DEFAULT_PORT] before the next Clk edge.
